ram_16x8_fifo_ctrl: RTL and testbench

//  FIFO controller sitting directly upstream of ram_16x8; it drives that RAM's we/re/addr/din
//  and consumes its dout. Converts a push/pop stream interface into single-port RAM accesses.

---
 rtl/ram_16x8_fifo_ctrl.sv | 122 ++++++++++++
 tb/tb_ram_16x8_fifo_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/ram_16x8_fifo_ctrl.sv
// FIFO controller driving a single-port ram_16x8: push/pop stream in, we/re/addr/din out.
// Ports: clk, rst, flush, wr_en/wr_data/wr_ready, rd_en/rd_valid/rd_data, count/empty/full/
// almost_full/busy, ram_we/ram_re/ram_addr/ram_din, ram_dout. Macro: CLEAR_ON_RST_EN.
module ram_16x8_fifo_ctrl #(
  parameter int DW           = 8,
  parameter int AW           = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  input  logic          rd_en,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full,
  output logic          almost_full,
  output logic          busy,
  output logic          ram_we,
  output logic          ram_re,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  localparam int DEPTH = 1 << AW;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          rd_valid_q, rd_valid_d;
  logic          run;
  logic          rd_fire;
  logic          wr_fire;

`ifdef CLEAR_ON_RST_EN
  typedef enum logic {INIT, RUN} state_e;
  state_e        state_q, state_d;
  logic [AW-1:0] init_addr_q, init_addr_d;
  assign run = (state_q == RUN);
`else
  assign run = 1'b1;
`endif

  assign count       = count_q;
  assign empty       = (count_q == '0);
  assign full        = (count_q == (AW+1)'(DEPTH));
  assign almost_full = (count_q >= (AW+1)'(AFULL_THRESH));
  assign busy        = ~run;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_valid_q ? ram_dout : '0;

  // Pop has priority on the single RAM port; flush blocks both.
  assign rd_fire  = rd_en & ~empty & run & ~flush;
  assign wr_ready = run & ~full & ~rd_fire;
  assign wr_fire  = wr_en & wr_ready & ~flush;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_valid_d = rd_fire;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_addr   = '0;
    ram_din    = '0;
`ifdef CLEAR_ON_RST_EN
    state_d     = state_q;
    init_addr_d = init_addr_q;
    if (state_q == INIT) begin
      ram_we      = 1'b1;
      ram_addr    = init_addr_q;
      init_addr_d = init_addr_q + 1'b1;
      if (init_addr_q == '1)
        state_d = RUN;
    end else
`endif
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else if (rd_fire) begin
      ram_re   = 1'b1;
      ram_addr = rd_ptr_q;
      rd_ptr_d = rd_ptr_q + 1'b1;
      count_d  = count_q - 1'b1;
    end else if (wr_fire) begin
      ram_we   = 1'b1;
      ram_addr = wr_ptr_q;
      ram_din  = wr_data;
      wr_ptr_d = wr_ptr_q + 1'b1;
      count_d  = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
`ifdef CLEAR_ON_RST_EN
      state_q     <= INIT;
      init_addr_q <= '0;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
`ifdef CLEAR_ON_RST_EN
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
`endif
    end
  end

endmodule

// File: tb/tb_ram_16x8_fifo_ctrl.sv
// Randomized + directed bench for ram_16x8_fifo_ctrl against a queue-based FIFO model.
// Includes a behavioural ram_16x8 so popped data travels through real RAM addressing.
module tb_ram_16x8_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       wr_ready;
  logic       rd_en = 1'b0;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic [4:0] count;
  logic       empty, full, almost_full, busy;
  logic       ram_we, ram_re;
  logic [3:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;

  always #5 clk = ~clk;

  ram_16x8_fifo_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush),
    .wr_en(wr_en), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data),
    .count(count), .empty(empty), .full(full),
    .almost_full(almost_full), .busy(busy),
    .ram_we(ram_we), .ram_re(ram_re), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    if (ram_re) ram_dout <= mem[ram_addr];
  end

`ifdef CLEAR_ON_RST_EN
  localparam int INIT_CYC = 16;
`else
  localparam int INIT_CYC = 0;
`endif

  int vectors = 0;
  int errs = 0;
  bit started = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int wptr = 0;
  int rptr = 0;
  int init_left = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every rd_valid pulse must match the next expected pop.
  always @(negedge clk) begin
    if (started) begin
      if (rd_valid) begin
        if (exp_q.size() == 0) chk("rd_valid_spurious", 32'(rd_valid), 32'd0);
        else chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
      end else if (exp_q.size() > 0) begin
        chk("rd_valid_missing", 32'(rd_valid), 32'd1);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic cyc(input logic r, input logic w, input logic [7:0] d,
                     input logic rd, input logic fl);
    bit pop, push;
    int n;
    logic [3:0] ea;
    logic [7:0] ed;
    @(negedge clk);
    rst = r; wr_en = w; wr_data = d; rd_en = rd; flush = fl;
    #1;
    n = fifo_q.size();
    pop = 0; push = 0;
    if (!r) begin
      chk("busy", 32'(busy), 32'(init_left > 0));
      chk("count", 32'(count), 32'(n));
      chk("empty", 32'(empty), 32'(n == 0));
      chk("full", 32'(full), 32'(n == 16));
      chk("almost_full", 32'(almost_full), 32'(n >= 12));
      if (init_left > 0) begin
        chk("init_we", 32'(ram_we), 32'd1);
        chk("init_re", 32'(ram_re), 32'd0);
        chk("init_addr", 32'(ram_addr), 32'(16 - init_left));
        chk("init_din", 32'(ram_din), 32'd0);
        chk("init_wr_ready", 32'(wr_ready), 32'd0);
      end else begin
        pop  = rd && n > 0 && !fl;
        push = w && n < 16 && !fl && !pop;
        ea = pop ? 4'(rptr) : (push ? 4'(wptr) : 4'd0);
        ed = push ? d : 8'd0;
        chk("ram_we", 32'(ram_we), 32'(push));
        chk("ram_re", 32'(ram_re), 32'(pop));
        chk("ram_addr", 32'(ram_addr), 32'(ea));
        chk("ram_din", 32'(ram_din), 32'(ed));
        if (!fl) chk("wr_ready", 32'(wr_ready), 32'(n < 16 && !pop));
      end
    end
    @(posedge clk);
    if (r) begin
      fifo_q.delete(); wptr = 0; rptr = 0; init_left = INIT_CYC;
      started = 1;
    end else if (init_left > 0) begin
      init_left--;
    end else if (fl) begin
      fifo_q.delete(); wptr = 0; rptr = 0;
    end else if (pop) begin
      exp_q.push_back(fifo_q.pop_front());
      rptr = (rptr + 1) % 16;
    end else if (push) begin
      fifo_q.push_back(d);
      wptr = (wptr + 1) % 16;
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(0, 0, 8'd0, 0, 0);
  endtask

  initial begin
    cyc(1, 0, 8'd0, 0, 0);
    idle(INIT_CYC + 1);
    cyc(0, 1, 8'd30, 0, 0);
    cyc(0, 0, 8'd0, 1, 0);
    idle(2);
    for (int i = 1; i <= 16; i++) cyc(0, 1, 8'(i), 0, 0);
    cyc(0, 1, 8'hFF, 0, 0);
    for (int i = 0; i < 16; i++) cyc(0, 0, 8'd0, 1, 0);
    cyc(0, 0, 8'd0, 1, 0);
    idle(2);
    for (int i = 0; i < 3; i++) cyc(0, 1, 8'(40 + i), 0, 0);
    cyc(0, 1, 8'd50, 1, 0);
    cyc(0, 1, 8'd50, 0, 0);
    cyc(0, 0, 8'd0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(0, 1, 8'(60 + i), 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 8'd0, 1, 0);
    for (int i = 0; i < 14; i++) cyc(0, 1, 8'(70 + i), 0, 0);
    cyc(0, 1, 8'hAA, 0, 1);
    cyc(0, 0, 8'd0, 1, 0);
    idle(2);
    for (int blk = 0; blk < 15; blk++) begin
      int wp = $urandom_range(20, 90);
      int rp = $urandom_range(20, 90);
      for (int i = 0; i < 200; i++) begin
        cyc(($urandom % 300) == 0,
            $urandom_range(0, 99) < wp,
            8'($urandom),
            $urandom_range(0, 99) < rp,
            ($urandom % 40) == 0);
      end
    end
    cyc(1, 0, 8'd0, 0, 0);
    idle(INIT_CYC + 3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
